// File: rtl/stmt_arbiter.sv
// Shares one declaration checker between two character requesters, one whole statement (up to ';') at a time.
// Define STMT_ARB_TIMEOUT_EN to force release of a stalled grant after TIMEOUT idle cycles.
module stmt_arbiter #(
  parameter int         TIMEOUT   = 16,
  parameter logic [7:0] IDLE_BYTE = 8'h20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic [7:0] chk_in,
  output logic       chk_rst,
  input  logic       chk_out,
  output logic       res0_valid,
  output logic       res1_valid,
  output logic       res_ok,
  output logic [7:0] ok_cnt0,
  output logic [7:0] ok_cnt1
);

  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1, FLUSH} state_t;

  state_t     state;
  logic       ptr;
  logic       tag1_valid, tag1_owner;
  logic       tag2_valid, tag2_owner;
  logic       xfer0, xfer1, xfer, semi, flush;
  logic [7:0] xfer_data;

`ifdef STMT_ARB_TIMEOUT_EN
  logic [7:0] stall;
  assign flush = (state == FLUSH);
`else
  assign flush = 1'b0;
`endif

  assign req0_ready = (state == GRANT0);
  assign req1_ready = (state == GRANT1);
  assign xfer0      = req0_ready & req0_valid;
  assign xfer1      = req1_ready & req1_valid;
  assign xfer       = xfer0 | xfer1;
  assign xfer_data  = xfer1 ? req1_data : req0_data;
  assign semi       = xfer & (xfer_data == 8'h3B);

  // Tag stage 2 lines up with the checker's verdict for the ';' accepted two cycles earlier.
  assign res0_valid = (tag2_valid & ~tag2_owner) | (flush & ~ptr);
  assign res1_valid = (tag2_valid & tag2_owner) | (flush & ptr);
  assign res_ok     = tag2_valid & chk_out & ~flush;
  assign chk_rst    = reset | flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      ptr        <= 1'b1;
      chk_in     <= IDLE_BYTE;
      tag1_valid <= 1'b0;
      tag1_owner <= 1'b0;
      tag2_valid <= 1'b0;
      tag2_owner <= 1'b0;
      ok_cnt0    <= 8'd0;
      ok_cnt1    <= 8'd0;
`ifdef STMT_ARB_TIMEOUT_EN
      stall      <= 8'd0;
`endif
    end else begin
      chk_in     <= xfer ? xfer_data : IDLE_BYTE;
      tag1_valid <= semi;
      tag1_owner <= xfer1;
      tag2_valid <= tag1_valid;
      tag2_owner <= tag1_owner;

      if (res0_valid & res_ok & (ok_cnt0 != 8'hFF)) ok_cnt0 <= ok_cnt0 + 8'd1;
      if (res1_valid & res_ok & (ok_cnt1 != 8'hFF)) ok_cnt1 <= ok_cnt1 + 8'd1;

      case (state)
        IDLE: begin
          // On a tie, ptr names the requester served last, so the other one wins.
          if (req0_valid && (!req1_valid || ptr)) state <= GRANT0;
          else if (req1_valid)                    state <= GRANT1;
        end
        GRANT0, GRANT1: begin
          if (semi) begin
            state <= IDLE;
            ptr   <= (state == GRANT1);
          end
`ifdef STMT_ARB_TIMEOUT_EN
          if (xfer) begin
            stall <= 8'd0;
          end else if (stall == 8'(TIMEOUT - 1)) begin
            state <= FLUSH;
            ptr   <= (state == GRANT1);
            stall <= 8'd0;
          end else begin
            stall <= stall + 8'd1;
          end
`endif
        end
        FLUSH:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
